fetch_sequencer: RTL

Fetch-stage controller that sequences the combinational instruction ROM for the pipelined ARM core. It owns the fetch PC and drives the ROM byte address. It buffers fetched words in a small prefetch FIFO, tagged with their PC, and hands them to decode over a valid/ready handshake. It also handles branch redirects and flushes, and raises a fault on out-of-range or misaligned fetch addresses.

---
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: ROM address/data, redirect input, decode handshake.
// master = fetch_sequencer side, slave = environment (ROM, decode, branch unit).
interface fetch_sequencer_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        dec_ready;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, fault, fetch_count,
        input  imem_instr, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, fault, fetch_count,
        output imem_instr, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: sequences the ROM into a PC-tagged prefetch FIFO.
// Optional FETCH_STATS_EN builds a saturating push counter on fetch_count.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [63:0] LAST_PC = 64'(MEM_SIZE) - 64'd4;
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] C_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] P_ONE = AW'(1);

    typedef enum logic {RUN, FAULT} state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          fault_q;
    logic [63:0]   pc_q  [FIFO_DEPTH];
    logic [31:0]   ins_q [FIFO_DEPTH];

    logic valid;
    logic pop;
    logic push;
    logic pc_ok;

    // pc <= MEM_SIZE-4 is the wrap-free form of pc+3 < MEM_SIZE
    function automatic logic legal(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_PC);
    endfunction

    assign valid = (count != '0);
    assign pc_ok = legal(pc);
    assign pop   = valid && bus.dec_ready;
    assign push  = (state == RUN) && pc_ok && !bus.redirect_valid
                 && ((count < DEPTH) || pop);

    assign bus.imem_addr = pc;
    assign bus.if_valid  = valid;
    assign bus.if_instr  = valid ? ins_q[head] : 32'd0;
    assign bus.if_pc     = valid ? pc_q[head] : 64'd0;
    assign bus.fault     = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            fault_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            pc    <= bus.redirect_pc;
            if (legal(bus.redirect_pc)) begin
                state <= RUN;
            end else begin
                state   <= FAULT;
                fault_q <= 1'b1;
            end
        end else begin
            if (push) begin
                pc_q[tail]  <= pc;
                ins_q[tail] <= bus.imem_instr;
                tail        <= tail + P_ONE;
                pc          <= pc + 64'd4;
            end
            if (pop) begin
                head <= head + P_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
            if (state == RUN && !pc_ok) begin
                state   <= FAULT;
                fault_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cnt <= '0;
        end else if (push && stat_cnt != 32'hFFFF_FFFF) begin
            stat_cnt <= stat_cnt + 32'd1;
        end
    end

    assign bus.fetch_count = stat_cnt;
`else
    assign bus.fetch_count = 32'd0;
`endif

endmodule
